// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - glyph constants and scan phase type for the multiplexed BCD display
package bcd_disp_pkg;

    // Active-high glyphs, bit order gfedcba.
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef enum logic [0:0] {
        PH_GUARD = 1'b0,
        PH_SHOW  = 1'b1
    } phase_e;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD nibble to active-high 7-segment glyph
module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_DASH;
        if (blank_i) begin
            glyph_o = SEG_OFF;
        end else begin
            case (digit_i)
                4'd0:    glyph_o = SEG_0;
                4'd1:    glyph_o = SEG_1;
                4'd2:    glyph_o = SEG_2;
                4'd3:    glyph_o = SEG_3;
                4'd4:    glyph_o = SEG_4;
                4'd5:    glyph_o = SEG_5;
                4'd6:    glyph_o = SEG_6;
                4'd7:    glyph_o = SEG_7;
                4'd8:    glyph_o = SEG_8;
                4'd9:    glyph_o = SEG_9;
                default: glyph_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/bcd_disp_scan.sv
// rtl/bcd_disp_scan.sv - latches BCD digits and scans them onto a shared 7-seg bus with guard time
module bcd_disp_scan
    import bcd_disp_pkg::*;
#(
    parameter int NDIG     = 8,
    parameter int SCAN_DIV = 1000,
    parameter int GUARD    = 2,
    parameter int ACT_LOW  = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [4*NDIG-1:0] bcd_in,
    input  logic              ovf_in,
    input  logic              blank_en,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   dig_sel,
    output logic              ovf_led
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0]  PC_GUARD = PC_W'(GUARD);
    localparam logic [PC_W-1:0]  PC_ONE   = PC_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [NDIG-1:0]  DIG_ONE  = NDIG'(1);

    logic [PC_W-1:0]   pc_q,     pc_d;
    logic [IDX_W-1:0]  idx_q,    idx_d;
    logic [4*NDIG-1:0] shadow_q, shadow_d;
    logic              ovf_q,    ovf_d;
    logic [6:0]        seg_q,    seg_d;
    logic [NDIG-1:0]   dig_q,    dig_d;

    logic [NDIG-1:0]   blank_mask;
    logic [3:0]        cur_digit;
    logic              cur_blank;
    logic [6:0]        glyph;
    phase_e            phase;

    // Walk down from the top digit; a digit is blanked while everything above it (and itself) is zero.
    always_comb begin
        logic run_zero;
        run_zero   = 1'b1;
        blank_mask = '0;
        for (int i = NDIG - 1; i >= 1; i--) begin
            run_zero      = run_zero & (shadow_q[4*i +: 4] == 4'd0);
            blank_mask[i] = blank_en & run_zero;
        end
    end

    assign cur_digit = shadow_q[{idx_q, 2'b00} +: 4];
    assign cur_blank = blank_mask[idx_q];
    assign phase     = (pc_q < PC_GUARD) ? PH_GUARD : PH_SHOW;

    bcd_to_seg u_dec (
        .digit_i (cur_digit),
        .blank_i (cur_blank),
        .glyph_o (glyph)
    );

    always_comb begin
        pc_d  = pc_q + PC_ONE;
        idx_d = idx_q;
        if (pc_q == PC_LAST) begin
            pc_d  = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
        end
        shadow_d = load ? bcd_in : shadow_q;
        ovf_d    = load ? ovf_in : ovf_q;
    end

    // Guard cycles drop every digit so the previous glyph cannot ghost onto the next digit.
    always_comb begin
        seg_d = SEG_OFF;
        dig_d = '0;
        if (phase == PH_SHOW) begin
            seg_d = glyph;
            dig_d = DIG_ONE << idx_q;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            pc_q     <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
            seg_q    <= SEG_OFF;
            dig_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            seg_q    <= seg_d;
            dig_q    <= dig_d;
        end
    end

    assign seg     = (ACT_LOW != 0) ? ~seg_q : seg_q;
    assign dig_sel = (ACT_LOW != 0) ? ~dig_q : dig_q;
    assign ovf_led = ovf_q;

endmodule

// File: tb/tb_bcd_disp_scan.sv
// tb/tb_bcd_disp_scan.sv - scoreboard bench for the multiplexed BCD display scanner
module tb_bcd_disp_scan;

    localparam int NDIG     = 8;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;

    localparam logic [6:0] GLYPH [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        logic [6:0] seg;
        logic [7:0] dig;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [31:0] bcd_in = '0;
    logic        ovf_in = 1'b0;
    logic        blank_en = 1'b1;
    logic [6:0]  seg;
    logic [7:0]  dig_sel;
    logic        ovf_led;

    int errors = 0;
    int checks = 0;

    logic [31:0] sh_m = '0;
    logic        ovf_m = 1'b0;
    int          pc_m = 0;
    int          idx_m = 0;
    exp_t        sb[$];

    bcd_disp_scan #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD),
        .ACT_LOW  (1)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .load     (load),
        .bcd_in   (bcd_in),
        .ovf_in   (ovf_in),
        .blank_en (blank_en),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .ovf_led  (ovf_led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_glyph(input logic [31:0] sh, input int i, input logic ben);
        logic [3:0] d;
        bit         all0;
        d    = sh[4*i +: 4];
        all0 = 1'b1;
        for (int j = i; j < NDIG; j++)
            if (sh[4*j +: 4] != 4'd0) all0 = 1'b0;
        if (ben && i > 0 && all0) return 7'h00;
        if (d > 4'd9) return 7'h40;
        return GLYPH[d];
    endfunction

    function automatic exp_t model_out(input int pc, input int idx, input logic [31:0] sh,
                                       input logic ben, input logic ld, input logic ovfi,
                                       input logic ovfm);
        exp_t       e;
        logic [7:0] one;
        one   = 8'h01 << idx;
        e.ovf = ld ? ovfi : ovfm;
        if (pc < GUARD) begin
            e.seg = 7'h7F;
            e.dig = 8'hFF;
        end else begin
            e.seg = ~ref_glyph(sh, idx, ben);
            e.dig = ~one;
        end
        return e;
    endfunction

    // Reference model: the expected post-edge outputs are queued at every clock edge.
    always @(posedge clk or posedge clr) begin
        if (clr) begin
            sh_m  <= '0;
            ovf_m <= 1'b0;
            pc_m  <= 0;
            idx_m <= 0;
            sb.delete();
            sb.push_back('{7'h7F, 8'hFF, 1'b0});
        end else begin
            sb.push_back(model_out(pc_m, idx_m, sh_m, blank_en, load, ovf_in, ovf_m));
            if (load) begin
                sh_m  <= bcd_in;
                ovf_m <= ovf_in;
            end
            if (pc_m == SCAN_DIV - 1) begin
                pc_m  <= 0;
                idx_m <= (idx_m == NDIG - 1) ? 0 : idx_m + 1;
            end else begin
                pc_m <= pc_m + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            chk("sb_seg", {25'd0, seg}, {25'd0, sb[0].seg});
            chk("sb_dig", {24'd0, dig_sel}, {24'd0, sb[0].dig});
            chk("sb_ovf", {31'd0, ovf_led}, {31'd0, sb[0].ovf});
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic goto(input int idx, input int pc);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 200 && !found; n++) begin
            step();
            if (idx_m == idx && pc_m == pc) found = 1'b1;
        end
        chk("goto", {31'd0, found}, 32'd1);
    endtask

    task automatic do_load(input logic [31:0] v, input logic o);
        bcd_in = v;
        ovf_in = o;
        load   = 1'b1;
        step();
        load   = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [6:0] s, input logic [7:0] d);
        chk({tag, "_seg"}, {25'd0, seg}, {25'd0, s});
        chk({tag, "_dig"}, {24'd0, dig_sel}, {24'd0, d});
    endtask

    initial begin
        #1 clr = 1'b1;
        repeat (3) step();
        expect_out("rst", 7'h7F, 8'hFF);
        chk("rst_ovf", {31'd0, ovf_led}, 32'd0);
        clr = 1'b0;

        goto(0, 2);
        expect_out("guard0", 7'h7F, 8'hFF);
        goto(0, 3);
        expect_out("first", 7'h40, 8'hFE);

        do_load(32'h0000_1234, 1'b0);
        goto(1, 4);
        expect_out("d1_3", 7'h30, 8'hFD);
        goto(5, 4);
        expect_out("blank5", 7'h7F, 8'hDF);

        blank_en = 1'b0;
        goto(5, 4);
        expect_out("noblank5", 7'h40, 8'hDF);
        blank_en = 1'b1;
        do_load(32'h0000_0000, 1'b0);
        goto(1, 4);
        expect_out("zero_b1", 7'h7F, 8'hFD);
        goto(0, 4);
        expect_out("zero_d0", 7'h40, 8'hFE);

        do_load(32'h0000_0B00, 1'b1);
        chk("ovf_set", {31'd0, ovf_led}, 32'd1);
        goto(2, 4);
        expect_out("dash", 7'h3F, 8'hFB);
        goto(1, 4);
        expect_out("inner0", 7'h40, 8'hFD);
        do_load(32'h0000_0B00, 1'b0);
        chk("ovf_clr", {31'd0, ovf_led}, 32'd0);

        goto(0, 7);
        do_load(32'h0000_0090, 1'b0);
        goto(1, 2);
        expect_out("adv_guard", 7'h7F, 8'hFF);
        goto(1, 3);
        expect_out("adv_new", 7'h10, 8'hFD);

        goto(3, 5);
        clr = 1'b1;
        #1;
        expect_out("clr_mid", 7'h7F, 8'hFF);
        step();
        clr = 1'b0;
        goto(0, 4);
        expect_out("restart0", 7'h40, 8'hFE);
        goto(1, 4);
        expect_out("restart1", 7'h7F, 8'hFD);

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
